// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the (16,11) Hamming byte-serial encoder.
//
// Contents:
//   - width constants (MSG_W, CW_W, BYTE_W, CNT_W)
//   - FSM state enum used by hamming_encoder
//   - codeword bit-position constants for the parity bits
//   - mask of the codeword positions that carry message bits
//   - constant helper functions mapping message bits <-> codeword positions
//
// Optional feature macro (consumed by hamming_parity_gen):
//   HAMMING_ENC_SECDED_EN  defined   -> p0 = even overall parity (SECDED)
//                          undefined -> p0 = 0 (SEC-only codeword)
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam int MSG_W  = 11;   // message bits b11..b1
    localparam int CW_W   = 16;   // codeword width including p0
    localparam int BYTE_W = 8;    // output byte width
    localparam int CNT_W  = 8;    // width of the emitted-word counter

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALC     = 2'd1,
        SEND_LSW = 2'd2,
        SEND_MSW = 2'd3
    } state_t;

    // Parity bit positions in the codeword.
    localparam int POS_P0 = 0;
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_P4 = 4;
    localparam int POS_P8 = 8;

    // Positions 3, 5..7 and 9..15 carry b1..b11 in ascending order.
    localparam logic [CW_W-1:0] DATA_POS_MASK = 16'hFEE8;

    // Index of the message bit stored at codeword position pos
    // (number of data positions below pos).
    function automatic int data_index(input int pos);
        int idx;
        idx = 0;
        for (int j = 0; j < CW_W; j++) begin
            if (j < pos && DATA_POS_MASK[j]) begin
                idx = idx + 1;
            end
        end
        return idx;
    endfunction

    // Codeword position holding message bit index idx (0 -> b1).
    function automatic int data_pos(input int idx);
        int pos;
        int seen;
        pos  = 0;
        seen = 0;
        for (int j = 0; j < CW_W; j++) begin
            if (DATA_POS_MASK[j]) begin
                if (seen == idx) begin
                    pos = j;
                end
                seen = seen + 1;
            end
        end
        return pos;
    endfunction

    // Message-bit mask covered by the parity bit at position ppos: a data bit
    // is covered when its codeword position has the ppos bit set.
    function automatic logic [MSG_W-1:0] msg_cover(input int ppos);
        logic [MSG_W-1:0] m;
        m = '0;
        for (int i = 0; i < MSG_W; i++) begin
            if ((data_pos(i) & ppos) != 0) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// -----------------------------------------------------------------------------
// hamming_parity_gen
// Purely combinational (16,11) Hamming codeword builder.
//
// Ports:
//   i_data      in  [MSG_W-1:0]  message bits, i_data[0]=b1 .. i_data[10]=b11
//   o_codeword  out [CW_W-1:0]   codeword: bit 0=p0, 1=p1, 2=p2, 3=b1, 4=p4,
//                                5..7=b2..b4, 8=p8, 9..15=b5..b11
//
// Optional feature macro: HAMMING_ENC_SECDED_EN
//   defined   -> p0 is the XOR of codeword bits 15..1 (even overall parity)
//   undefined -> p0 is tied to 0
// -----------------------------------------------------------------------------
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [MSG_W-1:0] i_data,
    output logic [CW_W-1:0]  o_codeword
);

    // Codeword bits 15..1; bit 0 (p0) is handled separately because it
    // depends on all of these.
    logic [CW_W-1:1] w_body;
    logic            w_p0;

    // Every position is either a message bit or a power-of-two parity bit.
    // A parity bit at position 2^k covers all data positions with bit k set,
    // so its coverage can be expressed directly as a message-bit mask.
    genvar gi;
    generate
        for (gi = 1; gi < CW_W; gi++) begin : g_pos
            if (DATA_POS_MASK[gi]) begin : g_data
                assign w_body[gi] = i_data[data_index(gi)];
            end else begin : g_parity
                localparam logic [MSG_W-1:0] COVER = msg_cover(gi);
                assign w_body[gi] = ^(i_data & COVER);
            end
        end
    endgenerate

`ifdef HAMMING_ENC_SECDED_EN
    assign w_p0 = ^w_body;
`else
    assign w_p0 = 1'b0;
`endif

    assign o_codeword = {w_body, w_p0};

endmodule

// File: rtl/hamming_encoder.sv
// -----------------------------------------------------------------------------
// hamming_encoder
// Accepts one 11-bit message word at a time, builds the 16-bit Hamming
// codeword one cycle later and emits it as two bytes (LSW then MSW) over a
// valid/ready interface. No input buffering: a new word is accepted only in
// IDLE, so accepted words are at least 4 cycles apart.
//
// Ports:
//   Clk         in   rising-edge clock
//   Reset_n     in   synchronous active-low reset
//   in_valid    in   in_data holds a message word
//   in_data     in   [10:0] message bits b11..b1 (in_data[0]=b1)
//   in_ready    out  word accepted this cycle when in_valid is also 1
//   out_valid   out  out_byte holds an encoded byte
//   out_byte    out  [7:0] encoded byte, LSW first then MSW
//   out_is_msw  out  1 while out_byte is the MSW
//   out_ready   in   consumer takes out_byte this cycle
//   words_done  out  [7:0] count of fully emitted codewords (wraps 255 -> 0)
//
// Optional feature macro: HAMMING_ENC_SECDED_EN (see hamming_parity_gen);
// selects SECDED (p0 = overall parity) instead of the SEC-only codeword.
// -----------------------------------------------------------------------------
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              in_valid,
    input  logic [MSG_W-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_is_msw,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  words_done
);

    state_t            r_state;
    state_t            w_state_next;
    logic [MSG_W-1:0]  r_data;
    logic [CW_W-1:0]   r_codeword;
    logic [CNT_W-1:0]  r_words_done;
    logic [CW_W-1:0]   w_codeword;

    hamming_parity_gen u_parity_gen (
        .i_data     (r_data),
        .o_codeword (w_codeword)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_state_next = SEND_LSW;
            end
            SEND_LSW: begin
                if (out_ready) begin
                    w_state_next = SEND_MSW;
                end
            end
            SEND_MSW: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // Outputs are forced quiet while Reset_n is low so that nothing is
    // advertised during reset, whatever state the register still holds.
    // out_byte is only non-zero while out_valid is high; the byte comes
    // straight from the registered codeword, so it cannot change while the
    // consumer is stalling.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_is_msw = 1'b0;
        out_byte   = '0;
        if (Reset_n) begin
            case (r_state)
                IDLE: begin
                    in_ready = 1'b1;
                end
                SEND_LSW: begin
                    out_valid = 1'b1;
                    out_byte  = r_codeword[BYTE_W-1:0];
                end
                SEND_MSW: begin
                    out_valid  = 1'b1;
                    out_is_msw = 1'b1;
                    out_byte   = r_codeword[CW_W-1:BYTE_W];
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // The word counter only advances on the MSW handshake, so a reset at
    // any earlier point drops the word without counting it.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_data       <= '0;
            r_codeword   <= '0;
            r_words_done <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_data <= in_data;
            end
            if (r_state == CALC) begin
                r_codeword <= w_codeword;
            end
            if (r_state == SEND_MSW && out_ready) begin
                r_words_done <= r_words_done + 1'b1;
            end
        end
    end

    assign words_done = r_words_done;

endmodule

// File: tb/tb_hamming_encoder.sv
module tb_hamming_encoder;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_is_msw;
    logic        out_ready = 1'b0;
    logic [7:0]  words_done;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int exp_wd   = 0;

    hamming_encoder dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .out_is_msw (out_is_msw),
        .out_ready  (out_ready),
        .words_done (words_done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Reference codeword built straight from the parity equations.
    function automatic logic [15:0] ref_cw(input logic [10:0] d);
        logic [11:1] b;
        logic p0, p1, p2, p4, p8;
        logic [15:0] cw;
        b  = d;
        p8 = b[5] ^ b[6] ^ b[7] ^ b[8] ^ b[9] ^ b[10] ^ b[11];
        p4 = b[2] ^ b[3] ^ b[4] ^ b[8] ^ b[9] ^ b[10] ^ b[11];
        p2 = b[1] ^ b[3] ^ b[4] ^ b[6] ^ b[7] ^ b[10] ^ b[11];
        p1 = b[1] ^ b[2] ^ b[4] ^ b[5] ^ b[7] ^ b[9] ^ b[11];
        cw = {b[11:5], p8, b[4:2], p4, b[1], p2, p1, 1'b0};
`ifdef HAMMING_ENC_SECDED_EN
        p0 = ^cw[15:1];
`else
        p0 = 1'b0;
`endif
        cw[0] = p0;
        return cw;
    endfunction

    // Drives one word with out_ready=1 and collects both bytes. Called and
    // left at a falling edge; returns with the DUT back in IDLE.
    task automatic run_word(input logic [10:0] d, output logic [7:0] lsw,
                            output logic [7:0] msw, output bit tmo, output int acc_cyc);
        int  n;
        bit  done;
        tmo = 1'b0;
        lsw = 8'hxx;
        msw = 8'hxx;
        n   = 0;
        while (!in_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!in_ready) tmo = 1'b1;
        acc_cyc   = cyc;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        done = 1'b0;
        n    = 0;
        while (!done && n < 10) begin
            if (out_valid && !out_is_msw) lsw = out_byte;
            if (out_valid && out_is_msw) begin
                msw  = out_byte;
                done = 1'b1;
            end
            @(negedge Clk);
            n++;
        end
        if (!done) tmo = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h7FF;
        out_ready = 1'b1;
        repeat (2) @(negedge Clk);
        chk_cnt++;
        if ({in_ready, out_valid, out_is_msw, out_byte} !== 11'd0) begin
            $display("FAIL reset_outputs: got rdy=%b vld=%b msw=%b byte=%h, need all 0",
                     in_ready, out_valid, out_is_msw, out_byte);
        end else pass_cnt++;
        chk_cnt++;
        if (words_done !== 8'd0) $display("FAIL reset_words_done: got %0d need 0", words_done);
        else pass_cnt++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Reset_n   = 1'b1;
        @(negedge Clk);
        chk_cnt++;
        if ({in_ready, out_valid, out_byte} !== {1'b1, 1'b0, 8'h00}) begin
            $display("FAIL reset_release: got rdy=%b vld=%b byte=%h, need rdy=1 vld=0 byte=00",
                     in_ready, out_valid, out_byte);
        end else pass_cnt++;
        exp_wd = 0;
        $display("reset: rdy=%b wd=%0d", in_ready, words_done);
    endtask

    task automatic test_vectors();
        logic [10:0] vec [3];
        logic [7:0]  exp_l [3];
        logic [7:0]  exp_m [3];
        logic [7:0]  l, m;
        bit          tmo;
        int          acc;
        vec[0] = 11'h000; exp_l[0] = 8'h00; exp_m[0] = 8'h00;
`ifdef HAMMING_ENC_SECDED_EN
        vec[1] = 11'h7FF; exp_l[1] = 8'hFF; exp_m[1] = 8'hFF;
        vec[2] = 11'h001; exp_l[2] = 8'h0F; exp_m[2] = 8'h00;
`else
        vec[1] = 11'h7FF; exp_l[1] = 8'hFE; exp_m[1] = 8'hFF;
        vec[2] = 11'h001; exp_l[2] = 8'h0E; exp_m[2] = 8'h00;
`endif
        for (int k = 0; k < 3; k++) begin
            run_word(vec[k], l, m, tmo, acc);
            exp_wd = (exp_wd + 1) % 256;
            $display("vector %0d: data=%h lsw=%h msw=%h wd=%0d", k, vec[k], l, m, words_done);
            chk_cnt++;
            if (tmo) $display("FAIL vector_timeout: word %h got no complete output, need 2 bytes", vec[k]);
            else pass_cnt++;
            chk_cnt++;
            if ({l, m} !== {exp_l[k], exp_m[k]}) begin
                $display("FAIL vector_bytes: data=%h got %h/%h need %h/%h",
                         vec[k], l, m, exp_l[k], exp_m[k]);
            end else pass_cnt++;
            chk_cnt++;
            if (words_done !== 8'(exp_wd)) begin
                $display("FAIL vector_words_done: got %0d need %0d", words_done, exp_wd);
            end else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] d;
        logic [15:0] cw;
        d  = 11'($urandom);
        cw = ref_cw(d);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        @(negedge Clk);
        in_valid = 1'b0;
        chk_cnt++;
        if ({in_ready, out_valid} !== 2'b00) begin
            $display("FAIL calc_state: got rdy=%b vld=%b need 0 0", in_ready, out_valid);
        end else pass_cnt++;
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if ({out_valid, out_is_msw, in_ready, out_byte} !== {3'b100, cw[7:0]}) begin
                $display("FAIL stall_lsw: cycle %0d got vld=%b msw=%b rdy=%b byte=%h need 1 0 0 %h",
                         i, out_valid, out_is_msw, in_ready, out_byte, cw[7:0]);
            end else pass_cnt++;
            @(negedge Clk);
        end
        out_ready = 1'b1;
        @(negedge Clk);
        chk_cnt++;
        if ({out_valid, out_is_msw, out_byte} !== {2'b11, cw[15:8]}) begin
            $display("FAIL stall_msw: got vld=%b msw=%b byte=%h need 1 1 %h",
                     out_valid, out_is_msw, out_byte, cw[15:8]);
        end else pass_cnt++;
        @(negedge Clk);
        exp_wd = (exp_wd + 1) % 256;
        $display("backpressure: data=%h cw=%h wd=%0d", d, cw, words_done);
        // out_ready held high in IDLE must not count anything.
        repeat (3) @(negedge Clk);
        chk_cnt++;
        if ({out_valid, in_ready, words_done} !== {2'b01, 8'(exp_wd)}) begin
            $display("FAIL idle_out_ready: got vld=%b rdy=%b wd=%0d need 0 1 %0d",
                     out_valid, in_ready, words_done, exp_wd);
        end else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_msw();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'($urandom);
        @(negedge Clk);
        in_valid = 1'b0;
        @(negedge Clk);
        out_ready = 1'b1;
        @(negedge Clk);
        chk_cnt++;
        if ({out_valid, out_is_msw} !== 2'b11) begin
            $display("FAIL msw_reached: got vld=%b msw=%b need 1 1", out_valid, out_is_msw);
        end else pass_cnt++;
        out_ready = 1'b0;
        Reset_n   = 1'b0;
        @(negedge Clk);
        chk_cnt++;
        if ({out_valid, in_ready, words_done} !== 10'd0) begin
            $display("FAIL reset_in_msw: got vld=%b rdy=%b wd=%0d need 0 0 0",
                     out_valid, in_ready, words_done);
        end else pass_cnt++;
        Reset_n = 1'b1;
        @(negedge Clk);
        exp_wd = 0;
        chk_cnt++;
        if ({out_valid, in_ready, words_done} !== {2'b01, 8'd0}) begin
            $display("FAIL reset_in_msw_release: got vld=%b rdy=%b wd=%0d need 0 1 0",
                     out_valid, in_ready, words_done);
        end else pass_cnt++;
        $display("reset in msw: wd=%0d rdy=%b", words_done, in_ready);
    endtask

    task automatic test_back_to_back();
        logic [10:0] d;
        logic [15:0] cw;
        logic [7:0]  l, m;
        bit          tmo;
        int          acc, prev_acc;
        prev_acc = 0;
        for (int k = 0; k < 256; k++) begin
            d  = 11'($urandom);
            cw = ref_cw(d);
            run_word(d, l, m, tmo, acc);
            exp_wd = (exp_wd + 1) % 256;
            $display("b2b %0d: data=%h lsw=%h msw=%h wd=%0d", k, d, l, m, words_done);
            chk_cnt++;
            if (tmo) $display("FAIL b2b_timeout: word %0d got no complete output", k);
            else pass_cnt++;
            chk_cnt++;
            if ({m, l} !== cw) $display("FAIL b2b_codeword: word %0d data=%h got %h%h need %h", k, d, m, l, cw);
            else pass_cnt++;
            chk_cnt++;
            if (words_done !== 8'(exp_wd)) $display("FAIL b2b_words_done: got %0d need %0d", words_done, exp_wd);
            else pass_cnt++;
            if (k > 0) begin
                chk_cnt++;
                if (acc - prev_acc !== 4) $display("FAIL b2b_spacing: got %0d cycles need 4", acc - prev_acc);
                else pass_cnt++;
            end
            prev_acc = acc;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_in_msw();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
